// File: rtl/code_correlator.sv
// Accumulate-and-dump C/A correlator: wipes the chip off I/Q samples and dumps one-code-period sums.
// Optional CORR_SATURATE_EN clamps the accumulators instead of letting them wrap.
module code_correlator #(
    parameter int IN_WIDTH    = 3,
    parameter int ACC_WIDTH   = 20,
    parameter int CODE_PERIOD = 16800
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        data_valid,
    input  logic signed [IN_WIDTH-1:0]  data_i,
    input  logic signed [IN_WIDTH-1:0]  data_q,
    input  logic                        ca_bit,
    input  logic [14:0]                 code_shift,
    output logic signed [ACC_WIDTH-1:0] acc_i,
    output logic signed [ACC_WIDTH-1:0] acc_q,
    output logic                        acc_valid,
    output logic                        slip,
    output logic [1:0]                  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        ACCUM = 2'd2
    } state_t;

    localparam logic [14:0] LAST_SHIFT = 15'(CODE_PERIOD - 1);

`ifdef CORR_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

    state_t                      state_r;
    logic [14:0]                 prev_shift;

    logic                        s1_valid;
    logic                        s1_first;
    logic                        s1_last;
    logic                        s1_abort;
    logic signed [IN_WIDTH:0]    s1_wi;
    logic signed [IN_WIDTH:0]    s1_wq;

    logic signed [ACC_WIDTH-1:0] sum_i;
    logic signed [ACC_WIDTH-1:0] sum_q;
    logic signed [ACC_WIDTH-1:0] fin_i;
    logic signed [ACC_WIDTH-1:0] fin_q;
    logic signed [ACC_WIDTH-1:0] nxt_i;
    logic signed [ACC_WIDTH-1:0] nxt_q;
    logic                        dump_pend;

    logic signed [IN_WIDTH:0]    ext_i;
    logic signed [IN_WIDTH:0]    ext_q;
    logic signed [IN_WIDTH:0]    wipe_i;
    logic signed [IN_WIDTH:0]    wipe_q;
    logic [14:0]                 next_shift;
    logic                        is_first;
    logic                        is_last;
    logic                        in_seq;

    assign state = state_r;

    // Extend before negating so the most negative sample maps to its positive magnitude.
    assign ext_i  = {data_i[IN_WIDTH-1], data_i};
    assign ext_q  = {data_q[IN_WIDTH-1], data_q};
    assign wipe_i = ca_bit ? ext_i : -ext_i;
    assign wipe_q = ca_bit ? ext_q : -ext_q;

    assign next_shift = (prev_shift == LAST_SHIFT) ? 15'd0 : prev_shift + 15'd1;
    assign is_first   = (code_shift == 15'd0);
    assign is_last    = (code_shift == LAST_SHIFT);
    assign in_seq     = (code_shift == next_shift);

    function automatic logic signed [ACC_WIDTH-1:0] acc_add(
        input logic signed [ACC_WIDTH-1:0] base,
        input logic signed [IN_WIDTH:0]    term
    );
`ifdef CORR_SATURATE_EN
        logic signed [ACC_WIDTH:0] wide;
        wide = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(term);
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
            acc_add = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            acc_add = wide[ACC_WIDTH-1:0];
`else
        acc_add = base + ACC_WIDTH'(term);
`endif
    endfunction

    // A first-of-window sample restarts the sum rather than adding to stale contents.
    assign nxt_i = acc_add(s1_first ? '0 : sum_i, s1_wi);
    assign nxt_q = acc_add(s1_first ? '0 : sum_q, s1_wq);

    // Window control and stage 1: decides which samples count and tags them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            prev_shift <= '0;
            slip       <= 1'b0;
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_abort   <= 1'b0;
            s1_wi      <= '0;
            s1_wq      <= '0;
        end else begin
            slip     <= 1'b0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_abort <= 1'b0;
            s1_wi    <= wipe_i;
            s1_wq    <= wipe_q;
            if (!enable) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: state_r <= SYNC;
                    SYNC: begin
                        if (data_valid && is_first) begin
                            state_r    <= ACCUM;
                            s1_valid   <= 1'b1;
                            s1_first   <= 1'b1;
                            s1_last    <= is_last;
                            prev_shift <= code_shift;
                        end
                    end
                    ACCUM: begin
                        if (data_valid) begin
                            if (in_seq) begin
                                s1_valid   <= 1'b1;
                                s1_first   <= is_first;
                                s1_last    <= is_last;
                                prev_shift <= code_shift;
                            end else begin
                                // Discontinuity: abort, then treat this sample as a SYNC candidate.
                                slip     <= 1'b1;
                                s1_abort <= 1'b1;
                                if (is_first) begin
                                    s1_valid   <= 1'b1;
                                    s1_first   <= 1'b1;
                                    s1_last    <= is_last;
                                    prev_shift <= code_shift;
                                end else begin
                                    state_r <= SYNC;
                                end
                            end
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    // Stage 2: accumulate, capture the final sum on the last sample, present it one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_i     <= '0;
            sum_q     <= '0;
            fin_i     <= '0;
            fin_q     <= '0;
            dump_pend <= 1'b0;
            acc_i     <= '0;
            acc_q     <= '0;
            acc_valid <= 1'b0;
        end else if (!enable) begin
            sum_i     <= '0;
            sum_q     <= '0;
            dump_pend <= 1'b0;
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= dump_pend;
            dump_pend <= 1'b0;
            if (dump_pend) begin
                acc_i <= fin_i;
                acc_q <= fin_q;
            end
            if (s1_valid) begin
                if (s1_last) begin
                    fin_i     <= nxt_i;
                    fin_q     <= nxt_q;
                    dump_pend <= 1'b1;
                    sum_i     <= '0;
                    sum_q     <= '0;
                end else begin
                    sum_i <= nxt_i;
                    sum_q <= nxt_q;
                end
            end else if (s1_abort) begin
                sum_i <= '0;
                sum_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_code_correlator.sv
// Directed bench for code_correlator: full-period main instance, 16-bit overflow instance, short-period instance.
module tb_code_correlator;

    localparam int P_MAIN  = 16800;
    localparam int P_SMALL = 20;
`ifdef CORR_SATURATE_EN
    localparam int W16_I = 32767;
    localparam int W16_Q = -32768;
`else
    localparam int W16_I = -15136;
    localparam int W16_Q = 31936;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              m_en = 1'b0, m_dv = 1'b0, m_ca = 1'b0;
    logic signed [2:0] m_di = '0, m_dq = '0;
    logic [14:0]       m_sh = '0;
    logic signed [19:0] m_acc_i, m_acc_q;
    logic              m_av, m_slip;
    logic [1:0]        m_state;
    logic signed [15:0] w_acc_i, w_acc_q;
    logic              w_av, w_slip;
    logic [1:0]        w_state;

    logic              s_en = 1'b0, s_dv = 1'b0, s_ca = 1'b0;
    logic signed [2:0] s_di = '0, s_dq = '0;
    logic [14:0]       s_sh = '0;
    logic signed [19:0] s_acc_i, s_acc_q;
    logic              s_av, s_slip;
    logic [1:0]        s_state;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int m_slips = 0, w_slips = 0, s_slips = 0;
    int m_sb_i[$], m_sb_q[$], m_sb_c[$];
    int w_sb_i[$], w_sb_q[$], w_sb_c[$];
    int s_sb_i[$], s_sb_q[$], s_sb_c[$];

    code_correlator #(.IN_WIDTH(3), .ACC_WIDTH(20), .CODE_PERIOD(P_MAIN)) dut_main (
        .clk(clk), .reset(reset), .enable(m_en), .data_valid(m_dv),
        .data_i(m_di), .data_q(m_dq), .ca_bit(m_ca), .code_shift(m_sh),
        .acc_i(m_acc_i), .acc_q(m_acc_q), .acc_valid(m_av), .slip(m_slip), .state(m_state)
    );

    code_correlator #(.IN_WIDTH(3), .ACC_WIDTH(16), .CODE_PERIOD(P_MAIN)) dut_w16 (
        .clk(clk), .reset(reset), .enable(m_en), .data_valid(m_dv),
        .data_i(m_di), .data_q(m_dq), .ca_bit(m_ca), .code_shift(m_sh),
        .acc_i(w_acc_i), .acc_q(w_acc_q), .acc_valid(w_av), .slip(w_slip), .state(w_state)
    );

    code_correlator #(.IN_WIDTH(3), .ACC_WIDTH(20), .CODE_PERIOD(P_SMALL)) dut_small (
        .clk(clk), .reset(reset), .enable(s_en), .data_valid(s_dv),
        .data_i(s_di), .data_q(s_dq), .ca_bit(s_ca), .code_shift(s_sh),
        .acc_i(s_acc_i), .acc_q(s_acc_q), .acc_valid(s_av), .slip(s_slip), .state(s_state)
    );

    task automatic check(input string tag, input int got, input int expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    task automatic m_drive(input int dv, input int di, input int dq, input int ca, input int sh);
        m_dv = (dv != 0);
        m_di = 3'(di);
        m_dq = 3'(dq);
        m_ca = (ca != 0);
        m_sh = 15'(sh);
        @(posedge clk);
        #1;
    endtask

    task automatic s_drive(input int dv, input int di, input int dq, input int ca, input int sh);
        s_dv = (dv != 0);
        s_di = 3'(di);
        s_dq = 3'(dq);
        s_ca = (ca != 0);
        s_sh = 15'(sh);
        @(posedge clk);
        #1;
    endtask

    task automatic s_run(input int from, input int to, input int di, input int dq, input int ca);
        for (int s = from; s <= to; s++) s_drive(1, di, dq, ca, s);
    endtask

    task automatic m_push_window();
        m_sb_i.push_back(50400);
        m_sb_q.push_back(-33600);
        m_sb_c.push_back(cyc + 2);
        w_sb_i.push_back(W16_I);
        w_sb_q.push_back(W16_Q);
        w_sb_c.push_back(cyc + 2);
    endtask

    task automatic s_push(input int ei, input int eq);
        s_sb_i.push_back(ei);
        s_sb_q.push_back(eq);
        s_sb_c.push_back(cyc + 2);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every dump must match the oldest queued expectation, value and cycle.
    always @(negedge clk) begin
        if (m_slip) m_slips++;
        if (w_slip) w_slips++;
        if (s_slip) s_slips++;
        if (m_av) begin
            if (m_sb_i.size() == 0) check("main_unexpected_dump", 1, 0);
            else begin
                check("main_acc_i", int'(m_acc_i), m_sb_i.pop_front());
                check("main_acc_q", int'(m_acc_q), m_sb_q.pop_front());
                check("main_dump_cycle", cyc, m_sb_c.pop_front());
            end
        end
        if (w_av) begin
            if (w_sb_i.size() == 0) check("w16_unexpected_dump", 1, 0);
            else begin
                check("w16_acc_i", int'(w_acc_i), w_sb_i.pop_front());
                check("w16_acc_q", int'(w_acc_q), w_sb_q.pop_front());
                check("w16_dump_cycle", cyc, w_sb_c.pop_front());
            end
        end
        if (s_av) begin
            if (s_sb_i.size() == 0) check("small_unexpected_dump", 1, 0);
            else begin
                check("small_acc_i", int'(s_acc_i), s_sb_i.pop_front());
                check("small_acc_q", int'(s_acc_q), s_sb_q.pop_front());
                check("small_dump_cycle", cyc, s_sb_c.pop_front());
            end
        end
    end

    initial begin
        // Reset held low with inputs toggling.
        for (int k = 0; k < 4; k++) begin
            m_en = 1'($urandom_range(0, 1));
            s_en = 1'($urandom_range(0, 1));
            m_drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, P_MAIN - 1));
            check("rst_main_acc_i", int'(m_acc_i), 0);
            check("rst_main_valid", int'(m_av), 0);
            check("rst_main_slip", int'(m_slip), 0);
            check("rst_main_state", int'(m_state), 0);
            check("rst_small_state", int'(s_state), 0);
        end
        m_en = 1'b0;
        s_en = 1'b0;
        reset = 1'b1;
        m_drive(0, 0, 0, 0, 0);
        check("idle_state", int'(m_state), 0);

        // Start mid-period: SYNC until shift 0 arrives.
        m_en = 1'b1;
        for (int s = 8000; s < P_MAIN; s++) m_drive(1, 3, -2, 1, s);
        check("sync_state", int'(m_state), 1);
        check("sync_acc_i_zero", int'(m_acc_i), 0);
        check("sync_acc_q_zero", int'(m_acc_q), 0);

        // Two back-to-back windows of constant data.
        for (int w = 0; w < 2; w++) begin
            for (int s = 0; s < P_MAIN; s++) begin
                m_drive(1, 3, -2, 1, s);
                if (s == 0) check("accum_state", int'(m_state), 2);
            end
            m_push_window();
        end

        // Same stream with random idle cycles carrying junk.
        for (int s = 0; s < P_MAIN; s++) begin
            while ($urandom_range(0, 9) < 3)
                m_drive(0, $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 1), $urandom_range(0, P_MAIN - 1));
            m_drive(1, 3, -2, 1, s);
        end
        m_push_window();
        for (int k = 0; k < 4; k++) m_drive(0, 0, 0, 0, 0);
        m_en = 1'b0;
        m_drive(0, 0, 0, 0, 0);
        check("main_off_state", int'(m_state), 0);
        check("main_keeps_acc_i", int'(m_acc_i), 50400);

        // Short-period instance.
        s_en = 1'b1;
        s_drive(0, 0, 0, 0, 0);
        s_run(15, 19, 3, 1, 1);
        check("small_sync_state", int'(s_state), 1);
        for (int s = 0; s < P_SMALL; s++) s_drive(1, 1, -3, (s % 2 == 0) ? 1 : 0, s);
        s_push(0, 0);
        s_run(0, 19, 3, 1, 1);
        s_push(60, 20);

        // Seek 5 -> 9: slip, resync at next 0.
        s_run(0, 5, 3, 1, 1);
        s_run(9, 19, 3, 1, 1);
        check("slip_count_1", s_slips, 1);
        check("slip_resync_state", int'(s_state), 1);
        s_run(0, 19, 3, 1, 1);
        s_push(60, 20);

        // Jump back to 0 mid-window: the violating sample opens the new window.
        s_run(0, 7, 3, 1, 1);
        s_run(0, 19, 3, 1, 1);
        s_push(60, 20);
        check("slip_count_2", s_slips, 2);

        // Most negative sample wiped by ca_bit=0.
        s_run(0, 19, -4, 2, 0);
        s_push(80, -40);

        // Enable drop mid-window: no dump, outputs held, SYNC ignores the tail.
        s_run(0, 10, 3, 1, 1);
        s_en = 1'b0;
        s_drive(0, 0, 0, 0, 0);
        check("drop_state", int'(s_state), 0);
        s_drive(0, 0, 0, 0, 0);
        s_drive(0, 0, 0, 0, 0);
        check("drop_keeps_acc_i", int'(s_acc_i), 80);
        check("drop_keeps_acc_q", int'(s_acc_q), -40);
        s_en = 1'b1;
        s_drive(0, 0, 0, 0, 0);
        s_run(11, 19, 3, 1, 1);
        s_run(0, 19, 3, 1, 1);
        s_push(60, 20);

        // Enable drop right after the last sample cancels the in-flight dump.
        s_run(0, 19, 2, -1, 1);
        s_en = 1'b0;
        for (int k = 0; k < 4; k++) s_drive(0, 0, 0, 0, 0);
        check("cancel_keeps_acc_i", int'(s_acc_i), 60);
        check("cancel_keeps_acc_q", int'(s_acc_q), 20);
        check("slip_count_final", s_slips, 2);
        check("main_slip_count", m_slips, 0);
        check("w16_slip_count", w_slips, 0);

        check("main_sb_empty", m_sb_i.size(), 0);
        check("w16_sb_empty", w_sb_i.size(), 0);
        check("small_sb_empty", s_sb_i.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
